ref_data_prefetcher: RTL and testbench

//  Parametrised successor to the single-slot reference-particle capture stage. Snoops the

---
 rtl/md_ref_pkg.sv | 27 ++
 rtl/ref_fifo.sv | 93 +++++++++
 rtl/ref_data_prefetcher.sv | 169 ++++++++++++++++
 tb/tb_ref_data_prefetcher.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/md_ref_pkg.sv
// Package: md_ref_pkg
// Shared types for the reference-particle prefetcher.
//   ref_state_e      : prefetcher FSM states (IDLE / WAIT_HDR / RUN / DONE)
//   ref_entry_t      : one buffered reference {id, x, y, z} at the default widths
//   DEFAULT_*        : default widths used by the top-level parameters
package md_ref_pkg;

  localparam int DEFAULT_OFFSET_WIDTH      = 29;
  localparam int DEFAULT_CELL_ID_WIDTH     = 3;
  localparam int DEFAULT_DATA_WIDTH        = DEFAULT_CELL_ID_WIDTH + DEFAULT_OFFSET_WIDTH;
  localparam int DEFAULT_PARTICLE_ID_WIDTH = 7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_HDR = 2'd1,
    ST_RUN      = 2'd2,
    ST_DONE     = 2'd3
  } ref_state_e;

  typedef struct packed {
    logic [DEFAULT_PARTICLE_ID_WIDTH-1:0] id;
    logic [DEFAULT_DATA_WIDTH-1:0]        x;
    logic [DEFAULT_DATA_WIDTH-1:0]        y;
    logic [DEFAULT_DATA_WIDTH-1:0]        z;
  } ref_entry_t;

endpackage

// File: rtl/ref_fifo.sv
// Module: ref_fifo
// Synchronous FIFO holding prefetched reference entries.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : empties the FIFO (pointers/occupancy cleared, head value held)
//   push, din  : write one entry (ignored when full)
//   pop        : retire the head entry (ignored when empty)
//   dout       : registered head entry; holds its last value while empty
//   full/empty : occupancy flags
// Push and pop in the same cycle both take effect. DEPTH must be a power of 2.
module ref_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [AW-1:0]    rd_next;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign dout  = head_q;

  always_comb begin
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    rd_next  = rd_ptr_q + 1'b1;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_next;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
      // The head register is a bypassed read: a push into an empty FIFO (or
      // one that is draining its last entry) lands directly on the output;
      // otherwise a pop fetches the next stored entry.
      if (do_push && (empty || (do_pop && count_q == ONE_C))) begin
        head_d = din;
      end else if (do_pop && count_q > ONE_C) begin
        head_d = mem[rd_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/ref_data_prefetcher.sv
// Module: ref_data_prefetcher
// Snoops the home-cell broadcast stream, latches the particle count from the
// header beat, and prefetches the next NUM_REF reference particles (in ID
// order) into a small FIFO feeding the force pipeline.
//   clk, rst                 : clock, synchronous active-high reset
//   start                    : begin a new home cell, flushes all state
//   hdr_valid                : header beat, count in raw_pos_x[PARTICLE_ID_WIDTH-1:0]
//   bcast_valid, bcast_id    : particle beat and its 1-based ID
//   raw_pos_x/y/z            : broadcast offsets
//   ref_advance              : pop the current reference
//   ref_valid, ref_id, ref_* : head of the buffer ({CELL_ID, offset} positions)
//   ref_particle_count       : latched count
//   cell_done                : every reference delivered and popped
//   err                      : sticky protocol error
// Optional feature macro: REF_PROTOCOL_CHECK_EN enables the err checker;
// without it err is tied to 0.
module ref_data_prefetcher
  import md_ref_pkg::*;
#(
  parameter int OFFSET_WIDTH      = DEFAULT_OFFSET_WIDTH,
  parameter int DATA_WIDTH        = DEFAULT_DATA_WIDTH,
  parameter int PARTICLE_ID_WIDTH = DEFAULT_PARTICLE_ID_WIDTH,
  parameter int CELL_ID_WIDTH     = DEFAULT_CELL_ID_WIDTH,
  parameter logic [CELL_ID_WIDTH-1:0] CELL_ID = 3'b010,
  parameter int NUM_REF           = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         hdr_valid,
  input  logic                         bcast_valid,
  input  logic [PARTICLE_ID_WIDTH-1:0] bcast_id,
  input  logic [OFFSET_WIDTH-1:0]      raw_pos_x,
  input  logic [OFFSET_WIDTH-1:0]      raw_pos_y,
  input  logic [OFFSET_WIDTH-1:0]      raw_pos_z,
  input  logic                         ref_advance,
  output logic                         ref_valid,
  output logic [PARTICLE_ID_WIDTH-1:0] ref_id,
  output logic [DATA_WIDTH-1:0]        ref_x,
  output logic [DATA_WIDTH-1:0]        ref_y,
  output logic [DATA_WIDTH-1:0]        ref_z,
  output logic [PARTICLE_ID_WIDTH-1:0] ref_particle_count,
  output logic                         cell_done,
  output logic                         err
);

  localparam int PID     = PARTICLE_ID_WIDTH;
  localparam int ENTRY_W = PID + 3 * DATA_WIDTH;

  ref_state_e           state_q, state_d;
  // One bit wider than the count so a full-scale count terminates cleanly.
  logic [PID:0]         capture_id_q, capture_id_d;
  logic [PID-1:0]       count_q, count_d;

  logic                 fifo_flush;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [ENTRY_W-1:0]   fifo_din;
  logic [ENTRY_W-1:0]   fifo_dout;
  logic                 capture_hit;

  assign fifo_din = {bcast_id,
                     CELL_ID, raw_pos_x,
                     CELL_ID, raw_pos_y,
                     CELL_ID, raw_pos_z};

  ref_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (NUM_REF)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    capture_id_d = capture_id_q;
    count_d      = count_q;
    fifo_flush   = 1'b0;
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;
    capture_hit  = (state_q == ST_RUN) && bcast_valid &&
                   ({1'b0, bcast_id} == capture_id_q) &&
                   (capture_id_q <= {1'b0, count_q});

    if (start) begin
      // start overrides every other input in the same cycle.
      fifo_flush   = 1'b1;
      state_d      = ST_WAIT_HDR;
      capture_id_d = {{PID{1'b0}}, 1'b1};
      count_d      = '0;
    end else begin
      fifo_pop  = ref_advance && !fifo_empty;
      // A match while full is dropped; the same ID is caught on a later pass.
      fifo_push = capture_hit && !fifo_full;
      if (fifo_push) capture_id_d = capture_id_q + 1'b1;

      case (state_q)
        ST_WAIT_HDR: begin
          if (hdr_valid) begin
            count_d = raw_pos_x[PID-1:0];
            state_d = (raw_pos_x[PID-1:0] == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (capture_id_q > {1'b0, count_q} && fifo_empty &&
              !fifo_push && !fifo_pop) begin
            state_d = ST_DONE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      capture_id_q <= {{PID{1'b0}}, 1'b1};
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      capture_id_q <= capture_id_d;
      count_q      <= count_d;
    end
  end

  assign ref_valid          = !fifo_empty;
  assign ref_id             = fifo_dout[ENTRY_W-1 -: PID];
  assign ref_x              = fifo_dout[3*DATA_WIDTH-1 -: DATA_WIDTH];
  assign ref_y              = fifo_dout[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign ref_z              = fifo_dout[DATA_WIDTH-1 -: DATA_WIDTH];
  assign ref_particle_count = count_q;
  assign cell_done          = (state_q == ST_DONE);

`ifdef REF_PROTOCOL_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (start) begin
      err_d = 1'b0;
    end else if ((ref_advance && fifo_empty) ||
                 (hdr_valid && state_q == ST_RUN) ||
                 (bcast_valid && state_q == ST_RUN && bcast_id > count_q)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ref_data_prefetcher.sv
module tb_ref_data_prefetcher;
  import md_ref_pkg::*;

  localparam int NUM_REF = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        hdr_valid = 1'b0;
  logic        bcast_valid = 1'b0;
  logic [6:0]  bcast_id = '0;
  logic [28:0] raw_pos_x = '0;
  logic [28:0] raw_pos_y = '0;
  logic [28:0] raw_pos_z = '0;
  logic        ref_advance = 1'b0;
  logic        ref_valid;
  logic [6:0]  ref_id;
  logic [31:0] ref_x, ref_y, ref_z;
  logic [6:0]  ref_particle_count;
  logic        cell_done;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ref_data_prefetcher dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .hdr_valid          (hdr_valid),
    .bcast_valid        (bcast_valid),
    .bcast_id           (bcast_id),
    .raw_pos_x          (raw_pos_x),
    .raw_pos_y          (raw_pos_y),
    .raw_pos_z          (raw_pos_z),
    .ref_advance        (ref_advance),
    .ref_valid          (ref_valid),
    .ref_id             (ref_id),
    .ref_x              (ref_x),
    .ref_y              (ref_y),
    .ref_z              (ref_z),
    .ref_particle_count (ref_particle_count),
    .cell_done          (cell_done),
    .err                (err)
  );

  // Reference model: phase 0 idle, 1 waiting for header, 2 running, 3 done.
  int         m_phase = 0;
  ref_entry_t m_q[$];
  int         m_cap = 1;
  int         m_cnt = 0;
  ref_entry_t m_last = '0;
  bit         m_err = 1'b0;

  function automatic logic [31:0] pos(input logic [28:0] o);
    return {3'b010, o};
  endfunction

  task automatic model_step();
    bit pushed;
    bit popped;
    int sz;
    ref_entry_t e;
    sz = m_q.size();
    if (rst) begin
      m_phase = 0; m_q.delete(); m_cap = 1; m_cnt = 0; m_last = '0; m_err = 1'b0;
    end else if (start) begin
      m_phase = 1; m_q.delete(); m_cap = 1; m_cnt = 0; m_err = 1'b0;
    end else begin
`ifdef REF_PROTOCOL_CHECK_EN
      if ((ref_advance && sz == 0) || (hdr_valid && m_phase == 2) ||
          (bcast_valid && m_phase == 2 && int'(bcast_id) > m_cnt))
        m_err = 1'b1;
`endif
      pushed = (m_phase == 2) && bcast_valid && (int'(bcast_id) == m_cap) &&
               (m_cap <= m_cnt) && (sz < NUM_REF);
      popped = ref_advance && (sz > 0);
      if (m_phase == 1 && hdr_valid) begin
        m_cnt   = int'(raw_pos_x[6:0]);
        m_phase = (m_cnt == 0) ? 3 : 2;
      end else if (m_phase == 2 && m_cap > m_cnt && sz == 0 && !pushed && !popped) begin
        m_phase = 3;
      end
      if (popped) void'(m_q.pop_front());
      if (pushed) begin
        e.id = bcast_id;
        e.x  = pos(raw_pos_x);
        e.y  = pos(raw_pos_y);
        e.z  = pos(raw_pos_z);
        m_q.push_back(e);
        m_cap++;
      end
    end
    if (m_q.size() > 0) m_last = m_q[0];
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("ref_valid", 64'(ref_valid), 64'(m_q.size() > 0));
    chk("ref_id", 64'(ref_id), 64'(m_last.id));
    chk("ref_x", 64'(ref_x), 64'(m_last.x));
    chk("ref_y", 64'(ref_y), 64'(m_last.y));
    chk("ref_z", 64'(ref_z), 64'(m_last.z));
    chk("ref_count", 64'(ref_particle_count), 64'(m_cnt));
    chk("cell_done", 64'(cell_done), 64'(m_phase == 3));
    chk("err", 64'(err), 64'(m_err));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0; start = 1'b0; hdr_valid = 1'b0; bcast_valid = 1'b0; ref_advance = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
  endtask

  task automatic do_hdr(input int n);
    hdr_valid = 1'b1;
    raw_pos_x = 29'($urandom);
    raw_pos_x[6:0] = 7'(n);
    tick();
  endtask

  task automatic do_bc(input int id, input bit adv);
    bcast_valid = 1'b1;
    bcast_id    = 7'(id);
    raw_pos_x   = 29'($urandom);
    raw_pos_y   = 29'($urandom);
    raw_pos_z   = 29'($urandom);
    ref_advance = adv;
    tick();
  endtask

  task automatic do_adv();
    ref_advance = 1'b1;
    tick();
  endtask

  logic exp_err;
  int   sweep;

  initial begin
`ifdef REF_PROTOCOL_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    @(negedge clk);
    rst = 1'b1; tick();
    rst = 1'b1; tick();
    chk("reset_valid", 64'(ref_valid), 64'd0);
    chk("reset_done", 64'(cell_done), 64'd0);

    // Count 3, IDs 1..3, then three advances.
    do_start();
    do_hdr(3);
    do_bc(1, 1'b0);
    chk("t1_valid_after_id1", 64'(ref_valid), 64'd1);
    chk("t1_head_id1", 64'(ref_id), 64'd1);
    do_bc(2, 1'b0);
    do_bc(3, 1'b0);
    do_adv(); do_adv(); do_adv();
    tick(); tick();
    chk("t1_cell_done", 64'(cell_done), 64'd1);

    // Count 10 with no advance: only four captured, then ID 5 on a re-pass.
    do_start();
    do_hdr(10);
    for (int i = 1; i <= 10; i++) do_bc(i, 1'b0);
    chk("t2_head_still_1", 64'(ref_id), 64'd1);
    do_adv();
    for (int i = 1; i <= 10; i++) do_bc(i, 1'b0);
    do_adv(); do_adv(); do_adv();
    chk("t2_id5_captured", 64'(ref_id), 64'd5);

    // Simultaneous push and pop keeps occupancy; then full + pop + match drops.
    do_bc(6, 1'b0);
    do_bc(7, 1'b0);
    do_bc(8, 1'b1);
    chk("t4_head_incremented", 64'(ref_id), 64'd6);
    do_bc(9, 1'b0);
    do_bc(10, 1'b1);
    for (int i = 0; i < 6; i++) do_adv();
    tick();

    // Header count 0.
    do_start();
    do_hdr(0);
    chk("t3_done_after_hdr", 64'(cell_done), 64'd1);
    chk("t3_no_valid", 64'(ref_valid), 64'd0);

    // start mid-RUN with two buffered entries.
    do_start();
    do_hdr(6);
    do_bc(1, 1'b0);
    do_bc(2, 1'b0);
    do_start();
    chk("t5_flushed", 64'(ref_valid), 64'd0);
    do_bc(1, 1'b0);
    chk("t5_waits_for_hdr", 64'(ref_valid), 64'd0);
    do_hdr(2);
    do_bc(1, 1'b0);
    do_bc(2, 1'b0);

    // Advance on empty.
    do_start();
    do_adv();
    chk("t6_err_set", 64'(err), 64'(exp_err));
    tick();
    chk("t6_err_sticky", 64'(err), 64'(exp_err));
    do_start();
    chk("t6_err_cleared", 64'(err), 64'd0);

    // Randomised traffic with sweeping broadcast passes.
    sweep = 1;
    for (int i = 0; i < 2000; i++) begin
      start     = ($urandom_range(0, 99) == 0);
      hdr_valid = ($urandom_range(0, 15) == 0);
      raw_pos_x = 29'($urandom);
      raw_pos_y = 29'($urandom);
      raw_pos_z = 29'($urandom);
      if (hdr_valid) raw_pos_x[6:0] = 7'($urandom_range(0, 10));
      bcast_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        bcast_id = 7'($urandom_range(0, 127));
      end else begin
        bcast_id = 7'(sweep);
        if (bcast_valid) sweep = (sweep >= 12) ? 1 : sweep + 1;
      end
      ref_advance = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
